// File: rtl/branch_pkg.sv
// Shared constants, flag payload and condition decode for the branch unit.
package branch_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned FC_W         = 5;

    localparam logic [FC_W-1:0] FC_NC = 5'd0;
    localparam logic [FC_W-1:0] FC_C  = 5'd1;
    localparam logic [FC_W-1:0] FC_S  = 5'd2;
    localparam logic [FC_W-1:0] FC_AL = 5'd3;
    localparam logic [FC_W-1:0] FC_Z  = 5'd4;
    localparam logic [FC_W-1:0] FC_NZ = 5'd5;

    typedef struct packed {
        logic s;
        logic z;
        logic c;
    } flags_t;

    // Branch condition from registered flags; unassigned codes never branch.
    function automatic logic cond_met(input logic [FC_W-1:0] fcode, input flags_t f);
        logic res;
        res = 1'b0;
        case (fcode)
            FC_NC:   res = ~f.c;
            FC_C:    res = f.c;
            FC_S:    res = f.s;
            FC_AL:   res = 1'b1;
            FC_Z:    res = f.z;
            FC_NZ:   res = ~f.z;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push on full overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            overflow,
    output logic            underflow
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   count;

    assign empty = (count == '0);
    assign full  = (count == CW'(RAS_DEPTH));
    assign top   = mem[ptr - PW'(1)];

    // Entry storage; contents are not reset, only the pointer/count are.
    always_ff @(posedge clk) begin
        if (push && !pop) begin
            mem[ptr] <= data;
        end
    end

    // Pointer, occupancy and one-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push && !pop && full;
            underflow <= pop && empty;
            if (pop) begin
                if (!empty) begin
                    ptr   <= ptr - PW'(1);
                    count <= count - CW'(1);
                end
            end else if (push) begin
                ptr <= ptr + PW'(1);
                if (!full) begin
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/branch_unit_ras.sv
// Branch decision, PC sequencing and call/return handling via a RAS.
module branch_unit_ras
    import branch_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEFAULT,
    parameter int unsigned     PC_STEP   = 4,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic            stall,
    input  logic            branch,
    input  logic            branch_src,
    input  logic [4:0]      fcode,
    input  logic            is_call,
    input  logic            is_ret,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] label,
    input  logic            flags_we,
    input  logic            sign,
    input  logic            zero,
    input  logic            carry,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] write_reg_data,
    output logic            taken,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    flags_t          flags;
    logic            accept;
    logic [XLEN-1:0] seq;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_next;
    logic            do_push;
    logic            do_pop;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;

    assign accept         = valid_in && !stall;
    assign seq            = pc + XLEN'(PC_STEP);
    assign target         = seq + (branch_src ? label : read_data1);
    assign taken          = accept && branch && cond_met(fcode, flags);
    assign write_reg_data = seq;
    assign do_pop         = accept && is_ret;
    assign do_push        = accept && !is_ret && taken && is_call;

    // Next PC: return wins over call; empty-stack return falls through.
    always_comb begin
        pc_next = pc;
        if (accept) begin
            if (is_ret) begin
                pc_next = ras_empty ? seq : ras_top;
            end else if (taken) begin
                pc_next = target;
            end else begin
                pc_next = seq;
            end
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Flag register; the new value only affects later decisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (accept && flags_we) begin
            flags <= '{s: sign, z: zero, c: carry};
        end
    end

    // Occupancy sanity: a stack cannot be empty and full at once.
    always_comb begin
        assert (!(ras_empty && ras_full));
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (do_push),
        .pop       (do_pop),
        .data      (seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

endmodule

// File: tb/tb_branch_unit_ras.sv
// Directed self-checking bench for branch_unit_ras (default parameters).
module tb_branch_unit_ras;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, stall, branch, branch_src;
    logic [4:0]  fcode;
    logic        is_call, is_ret;
    logic [31:0] read_data1, label;
    logic        flags_we, sign, zero, carry;
    logic [31:0] pc, write_reg_data;
    logic        taken, ras_overflow, ras_underflow;

    int checks   = 0;
    int failures = 0;

    logic [4:0] fc_tab  [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd31};
    logic       exp_tab [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    branch_unit_ras dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .stall          (stall),
        .branch         (branch),
        .branch_src     (branch_src),
        .fcode          (fcode),
        .is_call        (is_call),
        .is_ret         (is_ret),
        .read_data1     (read_data1),
        .label          (label),
        .flags_we       (flags_we),
        .sign           (sign),
        .zero           (zero),
        .carry          (carry),
        .pc             (pc),
        .write_reg_data (write_reg_data),
        .taken          (taken),
        .ras_overflow   (ras_overflow),
        .ras_underflow  (ras_underflow)
    );

    task automatic drive(input logic v, input logic st, input logic br, input logic src,
                         input logic [4:0] fc, input logic call, input logic ret,
                         input logic [31:0] rd1, input logic [31:0] lbl,
                         input logic fwe, input logic s, input logic z, input logic c);
        valid_in = v; stall = st; branch = br; branch_src = src; fcode = fc;
        is_call = call; is_ret = ret; read_data1 = rd1; label = lbl;
        flags_we = fwe; sign = s; zero = z; carry = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 5'd0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Reset, then unconditional jump to addr; optionally loads flags on the jump.
    task automatic jump_from_reset(input logic [31:0] addr, input logic fwe,
                                   input logic s, input logic z, input logic c);
        do_reset();
        drive(1, 0, 1, 1, 5'd3, 0, 0, 32'h0, addr - 32'd4, fwe, s, z, c);
        tick();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 5'd0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        checks++;
        if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++;
        if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            failures++; $display("FAIL reset_pulses got=%b%b exp=00", ras_overflow, ras_underflow);
        end
        checks++;
        if (write_reg_data !== 32'h4) begin failures++; $display("FAIL reset_link got=%h exp=%h", write_reg_data, 32'h4); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0, 0, 5'd3, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
            tick();
            checks++;
            if (pc !== 32'(4 * i)) begin failures++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, 32'(4 * i)); end
        end
        drive(0, 0, 0, 0, 5'd0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc !== 32'hC) begin failures++; $display("FAIL invalid_hold got=%h exp=%h", pc, 32'hC); end
    endtask

    task automatic test_cond();
        jump_from_reset(32'h100, 1, 0, 1, 0);
        checks++;
        if (pc !== 32'h100) begin failures++; $display("FAIL jump_100 got=%h exp=%h", pc, 32'h100); end
        drive(1, 0, 1, 1, 5'd4, 0, 0, 32'h0, 32'h20, 0, 0, 0, 0);
        #1;
        checks++;
        if (taken !== 1'b1) begin failures++; $display("FAIL z_taken got=%b exp=1", taken); end
        tick();
        checks++;
        if (pc !== 32'h124) begin failures++; $display("FAIL z_pc got=%h exp=%h", pc, 32'h124); end

        jump_from_reset(32'h100, 1, 0, 1, 0);
        drive(1, 0, 1, 1, 5'd5, 0, 0, 32'h0, 32'h20, 0, 0, 0, 0);
        #1;
        checks++;
        if (taken !== 1'b0) begin failures++; $display("FAIL nz_taken got=%b exp=0", taken); end
        tick();
        checks++;
        if (pc !== 32'h104) begin failures++; $display("FAIL nz_pc got=%h exp=%h", pc, 32'h104); end

        // Same-cycle flag write clears Z but the decision still sees Z=1.
        drive(1, 0, 1, 1, 5'd4, 0, 0, 32'h0, 32'h20, 1, 0, 0, 0);
        #1;
        checks++;
        if (taken !== 1'b1) begin failures++; $display("FAIL same_cycle_flags got=%b exp=1", taken); end
        tick();
        checks++;
        if (pc !== 32'h128) begin failures++; $display("FAIL same_cycle_pc got=%h exp=%h", pc, 32'h128); end

        // Load S=1 Z=0 C=1, then sweep condition codes.
        drive(1, 0, 0, 0, 5'd0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 1, 1, fc_tab[i], 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
            #1;
            checks++;
            if (taken !== exp_tab[i]) begin
                failures++; $display("FAIL fcode_%0d got=%b exp=%b", fc_tab[i], taken, exp_tab[i]);
            end
            tick();
        end
        checks++;
        if (pc !== 32'h14C) begin failures++; $display("FAIL sweep_pc got=%h exp=%h", pc, 32'h14C); end

        drive(1, 1, 1, 1, 5'd3, 0, 0, 32'h0, 32'h40, 0, 0, 0, 0);
        #1;
        checks++;
        if (taken !== 1'b0) begin failures++; $display("FAIL stall_taken got=%b exp=0", taken); end
        tick();
        checks++;
        if (pc !== 32'h14C) begin failures++; $display("FAIL stall_pc got=%h exp=%h", pc, 32'h14C); end

        drive(1, 0, 1, 0, 5'd3, 0, 0, 32'h10, 32'h999, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h160) begin failures++; $display("FAIL reg_offset_pc got=%h exp=%h", pc, 32'h160); end
    endtask

    task automatic test_call_ret();
        jump_from_reset(32'h200, 0, 0, 0, 0);
        drive(1, 0, 1, 1, 5'd3, 1, 0, 32'h0, 32'h40, 0, 0, 0, 0);
        #1;
        checks++;
        if (write_reg_data !== 32'h204) begin failures++; $display("FAIL call_link got=%h exp=%h", write_reg_data, 32'h204); end
        tick();
        checks++;
        if (pc !== 32'h244) begin failures++; $display("FAIL call_pc got=%h exp=%h", pc, 32'h244); end
        drive(1, 0, 0, 0, 5'd0, 0, 1, 32'h0, 32'h0, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h204 || ras_underflow !== 1'b0) begin
            failures++; $display("FAIL ret_pc got=%h/%b exp=%h/0", pc, ras_underflow, 32'h204);
        end
        // Call+ret together is a return only: empty stack, underflow, no push.
        drive(1, 0, 1, 1, 5'd3, 1, 1, 32'h0, 32'h40, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h208 || ras_underflow !== 1'b1) begin
            failures++; $display("FAIL callret_pc got=%h/%b exp=%h/1", pc, ras_underflow, 32'h208);
        end
        // Not-taken call does not push.
        drive(1, 0, 1, 1, 5'd6, 1, 0, 32'h0, 32'h40, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h20C || ras_underflow !== 1'b0) begin
            failures++; $display("FAIL nt_call got=%h/%b exp=%h/0", pc, ras_underflow, 32'h20C);
        end
        drive(1, 0, 0, 0, 5'd0, 0, 1, 32'h0, 32'h0, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h210 || ras_underflow !== 1'b1) begin
            failures++; $display("FAIL nt_call_ret got=%h/%b exp=%h/1", pc, ras_underflow, 32'h210);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pc;
        logic [31:0] ret_exp [4] = '{32'h414, 32'h310, 32'h20C, 32'h108};
        do_reset();
        exp_pc = 32'h0;
        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 1, 1, 5'd3, 1, 0, 32'h0, 32'h100, 0, 0, 0, 0);
            exp_pc = exp_pc + 32'h104;
            tick();
            checks++;
            if (pc !== exp_pc || ras_overflow !== (i == 5)) begin
                failures++; $display("FAIL call%0d got=%h/%b exp=%h/%b", i, pc, ras_overflow, exp_pc, (i == 5));
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 5'd0, 0, 1, 32'h0, 32'h0, 0, 0, 0, 0);
            tick();
            checks++;
            if (pc !== ret_exp[i] || ras_underflow !== 1'b0 || ras_overflow !== 1'b0) begin
                failures++; $display("FAIL ret%0d got=%h/%b exp=%h/0", i + 1, pc, ras_underflow, ret_exp[i]);
            end
        end
        drive(1, 0, 0, 0, 5'd0, 0, 1, 32'h0, 32'h0, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h10C || ras_underflow !== 1'b1) begin
            failures++; $display("FAIL ret5 got=%h/%b exp=%h/1", pc, ras_underflow, 32'h10C);
        end
        drive(0, 0, 0, 0, 5'd0, 0, 1, 32'h0, 32'h0, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h10C || ras_underflow !== 1'b0) begin
            failures++; $display("FAIL pulse_clear got=%h/%b exp=%h/0", pc, ras_underflow, 32'h10C);
        end
    endtask

    task automatic test_wrap_stall();
        jump_from_reset(32'hFFFF_FFFC, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 5'd0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
        drive(1, 1, 1, 1, 5'd3, 1, 0, 32'h0, 32'h80, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h0) begin failures++; $display("FAIL stall_call_pc got=%h exp=%h", pc, 32'h0); end
        drive(1, 0, 0, 0, 5'd0, 0, 1, 32'h0, 32'h0, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h4 || ras_underflow !== 1'b1) begin
            failures++; $display("FAIL stall_no_push got=%h/%b exp=%h/1", pc, ras_underflow, 32'h4);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 0, 1, 1, 5'd3, 1, 0, 32'h0, 32'h100, 0, 0, 0, 0);
        tick();
        drive(1, 0, 1, 1, 5'd3, 1, 0, 32'h0, 32'h100, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0) begin failures++; $display("FAIL async_reset_pc got=%h exp=%h", pc, 32'h0); end
        tick();
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 5'd0, 0, 1, 32'h0, 32'h0, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h4 || ras_underflow !== 1'b1) begin
            failures++; $display("FAIL post_reset_ret got=%h/%b exp=%h/1", pc, ras_underflow, 32'h4);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 5'd0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_sequential();
        test_cond();
        test_call_ret();
        test_overflow();
        test_wrap_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_unit_ras.md
BRANCH_UNIT_RAS -- requirements
Module: branch_unit_ras

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width.
REQ-002 SHALL have parameter PC_STEP, default 4, sequential PC increment.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-005 SHALL run on one clock with asynchronous, active-low reset.
REQ-006 ports, in order:
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- valid_in  in  1  instruction in this cycle is valid
- stall  in  1  hold all state
- branch  in  1  instruction is a branch
- branch_src  in  1  offset select: 1=label, 0=read_data1
- fcode  in  5  condition code
- is_call  in  1  branch is a call (push link)
- is_ret  in  1  return (pop RAS)
- read_data1  in  XLEN  register offset
- label  in  XLEN  immediate offset
- flags_we  in  1  latch sign/zero/carry
- sign, zero, carry  in  1 each  ALU flags
- pc  out  XLEN  current PC (registered)
- write_reg_data  out  XLEN  link value = pc+PC_STEP (combinational)
- taken  out  1  branch taken this cycle (combinational)
- ras_overflow  out  1  one-cycle pulse, push onto full RAS
- ras_underflow  out  1  one-cycle pulse, pop of empty RAS

Function
REQ-007 An instruction is accepted when valid_in=1 and stall=0; otherwise pc, flags, RAS and pulses hold (pulses drive 0).
REQ-008 Flag register {S,Z,C} updates on accepted cycles with flags_we=1; branch condition always uses the registered flags, so same-cycle flags_we has no effect on that cycle's decision.
REQ-009 fcode decode: 0 -> ~C, 1 -> C, 2 -> S, 3 -> always, 4 -> Z, 5 -> ~Z, 6..31 -> never.
REQ-010 taken = valid_in & ~stall & branch & cond(fcode).
REQ-011 Sequential PC seq = pc + PC_STEP; target = seq + (branch_src ? label : read_data1); all arithmetic modulo 2^XLEN, wrap-around silent.
REQ-012 Accepted, is_ret=1: pop RAS, pc <= popped value; if RAS empty, pc <= seq, ras_underflow pulses next cycle, count stays 0.
REQ-013 Accepted, is_ret=0, taken=1: pc <= target; if is_call=1 also push seq.
REQ-014 Accepted, not taken, not ret: pc <= seq; is_call ignored.
REQ-015 is_call and is_ret both high: treated as return only; no push.
REQ-016 Push on full RAS overwrites oldest entry (circular), count stays RAS_DEPTH, ras_overflow pulses next cycle.
REQ-017 Latency: pc reflects decision one clock after acceptance; write_reg_data and taken are same-cycle combinational.

Reset
REQ-018 rst_n=0 asynchronously sets pc=RESET_PC, flags=0, RAS count=0, pointer=0, ras_overflow=0, ras_underflow=0.
REQ-019 Reset mid-operation discards any in-flight push/pop; RAS entry contents need not be cleared.
REQ-020 First accepted instruction after rst_n rises uses pc=RESET_PC.

Structure
REQ-021 Package branch_pkg SHALL hold fcode constants (FC_NC, FC_C, FC_S, FC_AL, FC_Z, FC_NZ) and default XLEN.
REQ-022 Sub-module ras_stack (XLEN, RAS_DEPTH; push, pop, data, empty, full, overflow/underflow) SHALL implement the stack; decode and PC logic stay in branch_unit_ras.

Verification
REQ-023 Reset, then 3 accepted non-branch cycles -> pc = 0, 4, 8, 12.
REQ-024 pc=0x100, flags_we with Z=1, next cycle branch fcode=4 branch_src=1 label=0x20 -> taken=1, pc=0x124; same with fcode=5 -> pc=0x104.
REQ-025 pc=0x200 call, label=0x40 -> pc=0x244, RAS top=0x204; then ret -> pc=0x204.
REQ-026 RAS_DEPTH=4, 5 nested calls then 5 rets -> ras_overflow pulse on 5th call, first 4 rets return newest-first, 5th ret -> ras_underflow pulse, pc=seq.
REQ-027 pc=0xFFFFFFFC, non-branch -> pc=0x0; stall=1 with taken branch -> pc unchanged, no RAS change.
REQ-028 rst_n asserted mid-call cycle -> pc=RESET_PC immediately, RAS empty; subsequent ret -> underflow pulse.
